// File: rtl/bram_fifo_ctrl_pkg.sv
// bram_fifo_ctrl_pkg
// Shared constants, types and width helpers for the mem_bram FIFO
// controller and any other mem_bram user. Pointer and counter widths are
// derived here so every user of the store sizes its addresses the same way.

package bram_fifo_ctrl_pkg;

    // Default geometry of the pixel store.
    localparam int DEFAULT_BRAM_WIDTH = 12;
    localparam int DEFAULT_BRAM_DEPTH = 16384;

    // Output-register state: the only control state of the FIFO.
    // EMPTY_OUT means the output register is empty; HOLD means it holds a word.
    typedef enum logic [0:0] {
        ST_EMPTY_OUT = 1'b0,
        ST_HOLD      = 1'b1
    } rd_state_e;

    // Address width for a store of 'depth' words (PTR_W).
    // A depth of one still needs a one-bit address port.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width able to hold 0..depth inclusive (CNT_W).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : bram_fifo_ctrl_pkg

// File: rtl/mem_bram.sv
// mem_bram
// Simple dual-port pixel store: synchronous write port, combinational
// read port. The read path is asynchronous, so a consumer that needs a
// clean timing boundary must register the read data itself.

module mem_bram
    import bram_fifo_ctrl_pkg::*;
#(
    parameter  int BRAM_WIDTH = DEFAULT_BRAM_WIDTH,
    parameter  int BRAM_DEPTH = DEFAULT_BRAM_DEPTH,
    localparam int ADDR_W     = ptr_width(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [BRAM_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [BRAM_WIDTH-1:0] o_rdata
);

    logic [BRAM_WIDTH-1:0] mem_q [BRAM_DEPTH];

    // Write port: store the word on a write strobe; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : mem_bram

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
// Single-clock FIFO controller sequencing a mem_bram instance as an
// elastic pixel buffer. Wrapping write/read pointers, an occupancy counter
// and a registered ready/valid output stage keep the combinational BRAM
// read path away from downstream logic. i_flush acts as frame sync and
// returns everything to the reset state.
//
// Optional feature: define BRAM_FIFO_OVERFLOW_EN to build the sticky
// write-while-full flag on o_overflow; otherwise o_overflow is tied low.

module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter  int BRAM_WIDTH = DEFAULT_BRAM_WIDTH,
    parameter  int BRAM_DEPTH = DEFAULT_BRAM_DEPTH,
    localparam int PTR_W      = ptr_width(BRAM_DEPTH),
    localparam int CNT_W      = cnt_width(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wvalid,
    input  logic [BRAM_WIDTH-1:0] i_wdata,
    output logic                  o_wready,
    output logic                  o_rvalid,
    output logic [BRAM_WIDTH-1:0] o_rdata,
    input  logic                  i_rready,
    output logic [CNT_W-1:0]      o_fill,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BRAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BRAM_DEPTH);

    // Pointer advance with wrap from the last word back to zero; the depth
    // need not be a power of two, so natural binary rollover is not enough.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Registered state
    logic [PTR_W-1:0]      wptr_q,  wptr_d;
    logic [PTR_W-1:0]      rptr_q,  rptr_d;
    logic [CNT_W-1:0]      fill_q,  fill_d;
    logic                  full_q,  full_d;
    logic                  empty_q, empty_d;
    rd_state_e             state_q;
    logic [BRAM_WIDTH-1:0] rdata_q;

    // Per-cycle events
    logic                  accept_s;
    logic                  pop_s;
    logic                  consume_s;
    logic [BRAM_WIDTH-1:0] mem_rdata_s;

    // Write acceptance depends on registered full only, so a same-cycle pop
    // never opens a slot for a write. A pop needs a stored word and a free
    // (or simultaneously drained) output register; with fill at zero the pop
    // is blocked, so the BRAM never reads the address being written.
    assign accept_s  = i_wvalid && !full_q;
    assign pop_s     = !empty_q && ((state_q == ST_EMPTY_OUT) || i_rready);
    assign consume_s = (state_q == ST_HOLD) && i_rready;

    mem_bram #(
        .BRAM_WIDTH (BRAM_WIDTH),
        .BRAM_DEPTH (BRAM_DEPTH)
    ) u_mem_bram (
        .i_clk   (i_clk),
        .i_wr    (accept_s),
        .i_waddr (wptr_q),
        .i_wdata (i_wdata),
        .i_raddr (rptr_q),
        .o_rdata (mem_rdata_s)
    );

    // Next-state for pointers, occupancy and the derived full/empty flags.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;

        if (accept_s) begin
            wptr_d = ptr_next(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end

        if (pop_s) begin
            rptr_d = ptr_next(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end

        case ({accept_s, pop_s})
            2'b10:   fill_d = fill_q + CNT_W'(1);
            2'b01:   fill_d = fill_q - CNT_W'(1);
            default: fill_d = fill_q;
        endcase

        full_d  = (fill_d == CNT_FULL);
        empty_d = (fill_d == {CNT_W{1'b0}});
    end

    // Pointer/occupancy registers with reset and frame-sync clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            fill_q  <= {CNT_W{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (i_flush) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            fill_q  <= {CNT_W{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Output-stage FSM: loads the read register on pop, empties it on a
    // consume without refill; read data holds its last value when drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY_OUT;
            rdata_q <= {BRAM_WIDTH{1'b0}};
        end else if (i_flush) begin
            state_q <= ST_EMPTY_OUT;
            rdata_q <= {BRAM_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY_OUT: begin
                    if (pop_s) begin
                        state_q <= ST_HOLD;
                        rdata_q <= mem_rdata_s;
                    end else begin
                        state_q <= ST_EMPTY_OUT;
                        rdata_q <= rdata_q;
                    end
                end
                ST_HOLD: begin
                    if (pop_s) begin
                        state_q <= ST_HOLD;
                        rdata_q <= mem_rdata_s;
                    end else if (consume_s) begin
                        state_q <= ST_EMPTY_OUT;
                        rdata_q <= rdata_q;
                    end else begin
                        state_q <= ST_HOLD;
                        rdata_q <= rdata_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY_OUT;
                    rdata_q <= {BRAM_WIDTH{1'b0}};
                end
            endcase
        end
    end

`ifdef BRAM_FIFO_OVERFLOW_EN
    logic overflow_q;

    // Sticky overflow: any write attempt while full, cleared only by reset or flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (i_flush) begin
            overflow_q <= 1'b0;
        end else if (i_wvalid && full_q) begin
            overflow_q <= 1'b1;
        end else begin
            overflow_q <= overflow_q;
        end
    end

    assign o_overflow = overflow_q;
`else
    assign o_overflow = 1'b0;
`endif

    assign o_wready = !full_q;
    assign o_full   = full_q;
    assign o_empty  = empty_q;
    assign o_fill   = fill_q;
    assign o_rvalid = (state_q == ST_HOLD);
    assign o_rdata  = rdata_q;

endmodule : bram_fifo_ctrl

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl
// Self-checking bench for bram_fifo_ctrl at BRAM_DEPTH=16. A queue-based
// reference model tracks BRAM contents, output register and flags; a
// scoreboard of accepted words is popped and compared on every consume.

module tb_bram_fifo_ctrl;

    localparam int W  = 12;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);
`ifdef BRAM_FIFO_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          i_wvalid;
    logic [W-1:0]  i_wdata;
    logic          o_wready;
    logic          o_rvalid;
    logic [W-1:0]  o_rdata;
    logic          i_rready;
    logic [CW-1:0] o_fill;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] sb[$];
    int           m_fill;
    logic         m_rvalid;
    logic [W-1:0] m_rdata;
    logic         m_ovf;
    int           n_consumed;

    bram_fifo_ctrl #(
        .BRAM_WIDTH (W),
        .BRAM_DEPTH (D)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_wvalid   (i_wvalid),
        .i_wdata    (i_wdata),
        .o_wready   (o_wready),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .i_rready   (i_rready),
        .o_fill     (o_fill),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, advance the model, check consumed data
    // against the scoreboard, then wait past the edge.
    task automatic step(input logic rs, input logic fl, input logic wv,
                        input logic [W-1:0] wd, input logic rr);
        logic acc, pop, cons;
        logic [W-1:0] exp;
        i_rst    = rs;
        i_flush  = fl;
        i_wvalid = wv;
        i_wdata  = wd;
        i_rready = rr;
        if (rs || fl) begin
            mq.delete();
            sb.delete();
            m_fill   = 0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_ovf    = 1'b0;
        end else begin
            acc  = wv && (m_fill < D);
            pop  = (m_fill != 0) && (!m_rvalid || rr);
            cons = m_rvalid && rr;
            if (wv && (m_fill == D) && OVF_EN) m_ovf = 1'b1;
            if (cons) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got %h want <no word>", o_rdata);
                end else begin
                    exp = sb.pop_front();
                    if (o_rdata !== exp) begin
                        errors++;
                        $display("FAIL sb_data got %h want %h", o_rdata, exp);
                    end
                end
                n_consumed++;
            end
            if (pop) begin
                m_rdata  = mq.pop_front();
                m_rvalid = 1'b1;
            end else if (cons) begin
                m_rvalid = 1'b0;
            end
            if (acc) begin
                mq.push_back(wd);
                sb.push_back(wd);
            end
            m_fill = mq.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (o_fill !== CW'(0))   begin errors++; $display("FAIL reset_fill got %0d want 0", o_fill); end
        checks++; if (o_empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
        checks++; if (o_full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
        checks++; if (o_wready !== 1'b1)   begin errors++; $display("FAIL reset_wready got %b want 1", o_wready); end
        checks++; if (o_rvalid !== 1'b0)   begin errors++; $display("FAIL reset_rvalid got %b want 0", o_rvalid); end
        checks++; if (o_rdata !== W'(0))   begin errors++; $display("FAIL reset_rdata got %h want 000", o_rdata); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
    endtask

    task automatic test_single_write();
        step(1'b0, 1'b0, 1'b1, 12'hABC, 1'b0);
        checks++; if (o_fill !== CW'(1))  begin errors++; $display("FAIL single_fill1 got %0d want 1", o_fill); end
        checks++; if (o_rvalid !== 1'b0)  begin errors++; $display("FAIL single_rvalid1 got %b want 0", o_rvalid); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (o_rvalid !== 1'b1)  begin errors++; $display("FAIL single_rvalid2 got %b want 1", o_rvalid); end
        checks++; if (o_rdata !== 12'hABC) begin errors++; $display("FAIL single_rdata got %h want abc", o_rdata); end
        checks++; if (o_fill !== CW'(0))  begin errors++; $display("FAIL single_fill2 got %0d want 0", o_fill); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (o_rvalid !== 1'b0)  begin errors++; $display("FAIL single_drain got %b want 0", o_rvalid); end
    endtask

    task automatic test_fill_full();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, W'(12'h200 + i), 1'b0);
        checks++; if (o_full !== 1'b1)    begin errors++; $display("FAIL full_full got %b want 1", o_full); end
        checks++; if (o_wready !== 1'b0)  begin errors++; $display("FAIL full_wready got %b want 0", o_wready); end
        checks++; if (o_fill !== CW'(16)) begin errors++; $display("FAIL full_fill got %0d want 16", o_fill); end
        checks++; if (o_rvalid !== 1'b1)  begin errors++; $display("FAIL full_rvalid got %b want 1", o_rvalid); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early got %b want 0", o_overflow); end
        step(1'b0, 1'b0, 1'b1, 12'hEEE, 1'b0);
        checks++; if (o_overflow !== OVF_EN) begin errors++; $display("FAIL full_ovf got %b want %b", o_overflow, OVF_EN); end
        checks++; if (o_fill !== CW'(16))    begin errors++; $display("FAIL full_fill_hold got %0d want 16", o_fill); end
        // Write refused even while a pop frees a slot the same cycle.
        step(1'b0, 1'b0, 1'b1, 12'hDDD, 1'b1);
        checks++; if (o_fill !== CW'(15))    begin errors++; $display("FAIL full_refuse got %0d want 15", o_fill); end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (o_empty !== 1'b1 || o_rvalid !== 1'b0) begin
            errors++; $display("FAIL full_drain got empty=%b rvalid=%b want 1/0", o_empty, o_rvalid);
        end
        checks++; if (o_overflow !== OVF_EN) begin errors++; $display("FAIL full_ovf_sticky got %b want %b", o_overflow, OVF_EN); end
    endtask

    task automatic test_wrap();
        int   sent   = 0;
        int   budget = 0;
        logic wv, rr, will_acc;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        n_consumed = 0;
        while ((sent < 40 || n_consumed < 40) && budget < 800) begin
            wv = (sent < 40) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 1) == 1);
            will_acc = wv && (m_fill < D);
            step(1'b0, 1'b0, wv, W'(12'h100 + sent), rr);
            if (will_acc) sent++;
            checks++;
            if (o_fill !== CW'(m_fill) || o_rvalid !== m_rvalid) begin
                errors++;
                $display("FAIL wrap_state got fill=%0d rvalid=%b want fill=%0d rvalid=%b",
                         o_fill, o_rvalid, m_fill, m_rvalid);
            end
            budget++;
        end
        checks++; if (n_consumed != 40) begin errors++; $display("FAIL wrap_count got %0d want 40", n_consumed); end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, W'(12'h300 + i), 1'b0);
        checks++; if (o_fill !== CW'(5)) begin errors++; $display("FAIL simul_pre got %0d want 5", o_fill); end
        step(1'b0, 1'b0, 1'b1, 12'h3FF, 1'b1);
        checks++; if (o_fill !== CW'(5)) begin errors++; $display("FAIL simul_fill got %0d want 5", o_fill); end
        checks++; if (o_rdata !== 12'h301 || o_rvalid !== 1'b1) begin
            errors++; $display("FAIL simul_rdata got %h/%b want 301/1", o_rdata, o_rvalid);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL simul_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, W'(12'h400 + i), 1'b0);
        checks++; if (o_fill !== CW'(7) || o_rvalid !== 1'b1) begin
            errors++; $display("FAIL flush_pre got fill=%0d rvalid=%b want 7/1", o_fill, o_rvalid);
        end
        step(1'b0, 1'b1, 1'b1, 12'h777, 1'b1);
        checks++; if (o_fill !== CW'(0))     begin errors++; $display("FAIL flush_fill got %0d want 0", o_fill); end
        checks++; if (o_rvalid !== 1'b0)     begin errors++; $display("FAIL flush_rvalid got %b want 0", o_rvalid); end
        checks++; if (o_overflow !== 1'b0)   begin errors++; $display("FAIL flush_ovf got %b want 0", o_overflow); end
        checks++; if (o_empty !== 1'b1 || o_wready !== 1'b1) begin
            errors++; $display("FAIL flush_flags got empty=%b wready=%b want 1/1", o_empty, o_wready);
        end
        checks++; if (o_rdata !== W'(0))     begin errors++; $display("FAIL flush_rdata got %h want 000", o_rdata); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (o_rvalid !== 1'b0 || o_fill !== CW'(0)) begin
            errors++; $display("FAIL flush_discard got rvalid=%b fill=%0d want 0/0", o_rvalid, o_fill);
        end
    endtask

    task automatic test_consume_empty();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 12'h5A5, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (o_rvalid !== 1'b1 || o_fill !== CW'(0)) begin
            errors++; $display("FAIL cempty_pre got rvalid=%b fill=%0d want 1/0", o_rvalid, o_fill);
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (o_rvalid !== 1'b0)   begin errors++; $display("FAIL cempty_rvalid got %b want 0", o_rvalid); end
        checks++; if (o_rdata !== 12'h5A5) begin errors++; $display("FAIL cempty_rdata got %h want 5a5", o_rdata); end
    endtask

    initial begin
        i_rst    = 1'b1;
        i_flush  = 1'b0;
        i_wvalid = 1'b0;
        i_wdata  = '0;
        i_rready = 1'b0;
        m_fill   = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_ovf    = 1'b0;
        n_consumed = 0;
        test_reset();
        test_single_write();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_consume_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bram_fifo_ctrl
